// File: rtl/opb_pkg.sv
// Shared OPB definitions: master FSM states, GPIO slave register map and
// slave-select field defaults.
package opb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_RESP
  } opb_state_t;

  // GPIO slave register offsets
  localparam logic [3:0] GPIO_IN   = 4'h0;
  localparam logic [3:0] SWITCH_IN = 4'h1;
  localparam logic [3:0] GPIO_OUT  = 4'h2;
  localparam logic [3:0] TP_OUT    = 4'h3;

  localparam int SEL_LSB_DEF = 4;
  localparam int SEL_W_DEF   = 4;

endpackage

// File: rtl/opb_slv_decode.sv
// Combinational slave-select decode: one-hot select plus mapped flag for
// the slave-index field of a request address.
module opb_slv_decode #(
  parameter int NUM_SLV = 4,
  parameter int SEL_W   = 4
) (
  input  logic [SEL_W-1:0]   sel_field,
  output logic               mapped,
  output logic [NUM_SLV-1:0] sel
);

  assign mapped = (32'(sel_field) < 32'(NUM_SLV));

  for (genvar g = 0; g < NUM_SLV; g++) begin : g_sel
    assign sel[g] = (32'(sel_field) == 32'(g));
  end

endmodule

// File: rtl/opb_bus_master.sv
// Single-outstanding OPB bus master: converts a valid/ready command into a
// one-cycle slave strobe and returns a held response with error flag.
module opb_bus_master
  import opb_pkg::*;
#(
  parameter int NUM_SLV = 4,
  parameter int SEL_LSB = SEL_LSB_DEF,
  parameter int SEL_W   = SEL_W_DEF,
  parameter int RD_LAT  = 1
) (
  input  logic               OPB_CLK,
  input  logic               OPB_RST,
  input  logic               REQ_VALID,
  output logic               REQ_READY,
  input  logic               REQ_WR,
  input  logic [31:0]        REQ_ADDR,
  input  logic [31:0]        REQ_WDATA,
  output logic               RSP_VALID,
  input  logic               RSP_READY,
  output logic [31:0]        RSP_RDATA,
  output logic               RSP_ERR,
  output logic [31:0]        OPB_ADDR,
  output logic [31:0]        OPB_WDATA,
  input  logic [31:0]        OPB_RDATA,
  output logic [NUM_SLV-1:0] OPB_RE,
  output logic [NUM_SLV-1:0] OPB_WE,
  output logic               BUSY
);

  opb_state_t         state;
  logic               wr_q;
  logic [2:0]         wait_cnt;
  logic               mapped;
  logic [NUM_SLV-1:0] sel;

  opb_slv_decode #(
    .NUM_SLV (NUM_SLV),
    .SEL_W   (SEL_W)
  ) u_dec (
    .sel_field (REQ_ADDR[SEL_LSB+SEL_W-1:SEL_LSB]),
    .mapped    (mapped),
    .sel       (sel)
  );

  assign REQ_READY = (state == ST_IDLE);
  assign BUSY      = (state != ST_IDLE);

  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      state     <= ST_IDLE;
      wr_q      <= 1'b0;
      wait_cnt  <= '0;
      OPB_ADDR  <= '0;
      OPB_WDATA <= '0;
      OPB_RE    <= '0;
      OPB_WE    <= '0;
      RSP_VALID <= 1'b0;
      RSP_RDATA <= '0;
      RSP_ERR   <= 1'b0;
    end else begin
      // strobes are single-cycle pulses; only the IDLE accept can raise them
      OPB_RE <= '0;
      OPB_WE <= '0;
      case (state)
        ST_IDLE: begin
          if (REQ_VALID) begin
            OPB_ADDR  <= REQ_ADDR;
            OPB_WDATA <= REQ_WDATA;
            wr_q      <= REQ_WR;
            if (mapped) begin
              state <= ST_ACCESS;
              if (REQ_WR) OPB_WE <= sel;
              else        OPB_RE <= sel;
            end else begin
              state     <= ST_RESP;
              RSP_VALID <= 1'b1;
              RSP_RDATA <= '0;
              RSP_ERR   <= 1'b1;
            end
          end
        end
        ST_ACCESS: begin
          if (wr_q) begin
            state     <= ST_RESP;
            RSP_VALID <= 1'b1;
            RSP_RDATA <= '0;
            RSP_ERR   <= 1'b0;
          end else begin
            state    <= ST_WAIT;
            wait_cnt <= '0;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 3'(RD_LAT - 1)) begin
            state     <= ST_RESP;
            RSP_VALID <= 1'b1;
            RSP_RDATA <= OPB_RDATA;
            RSP_ERR   <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        ST_RESP: begin
          if (RSP_READY) begin
            state     <= ST_IDLE;
            RSP_VALID <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_opb_bus_master.sv
// Directed bench: GPIO slave model on a RD_LAT=1 master, plus a RD_LAT=3
// master used for latency and mid-transaction reset.
module tb_opb_bus_master;
  import opb_pkg::*;

  logic        clk = 1'b0;
  logic        rst, rst3;
  logic        req_valid, req_valid3, req_wr;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_ready, rsp_ready3;

  logic        req_ready, rsp_valid, rsp_err, busy;
  logic [31:0] rsp_rdata, opb_addr, opb_wdata, opb_rdata;
  logic [3:0]  opb_re, opb_we;

  logic        req_ready3, rsp_valid3, rsp_err3, busy3;
  logic [31:0] rsp_rdata3, opb_addr3, opb_wdata3;
  logic [3:0]  opb_re3, opb_we3;

  logic [31:0] gpio_out = '0;
  logic [31:0] rdata_q  = '0;
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  opb_bus_master #(.NUM_SLV(4), .SEL_LSB(4), .SEL_W(4), .RD_LAT(1)) u_dut (
    .OPB_CLK(clk), .OPB_RST(rst),
    .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_WR(req_wr),
    .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata),
    .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_RDATA(rsp_rdata), .RSP_ERR(rsp_err),
    .OPB_ADDR(opb_addr), .OPB_WDATA(opb_wdata), .OPB_RDATA(opb_rdata),
    .OPB_RE(opb_re), .OPB_WE(opb_we), .BUSY(busy)
  );

  opb_bus_master #(.NUM_SLV(4), .SEL_LSB(4), .SEL_W(4), .RD_LAT(3)) u_dut3 (
    .OPB_CLK(clk), .OPB_RST(rst3),
    .REQ_VALID(req_valid3), .REQ_READY(req_ready3), .REQ_WR(req_wr),
    .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata),
    .RSP_VALID(rsp_valid3), .RSP_READY(rsp_ready3), .RSP_RDATA(rsp_rdata3), .RSP_ERR(rsp_err3),
    .OPB_ADDR(opb_addr3), .OPB_WDATA(opb_wdata3), .OPB_RDATA(32'hCAFE0003),
    .OPB_RE(opb_re3), .OPB_WE(opb_we3), .BUSY(busy3)
  );

  // GPIO slave 0: GPIO_OUT register, read data presented one cycle after RE
  always_ff @(posedge clk) begin
    if (opb_we[0] && opb_addr[3:0] == GPIO_OUT) gpio_out <= opb_wdata;
    rdata_q <= (opb_re[0] && opb_addr[3:0] == GPIO_OUT) ? gpio_out : 32'h0;
  end
  assign opb_rdata = rdata_q;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1; rst3 = 1'b1;
    req_valid = 1'b0; req_valid3 = 1'b0; req_wr = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0; rsp_ready3 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_opb_addr", opb_addr, 0);
    chk("rst_strobes", {opb_re, opb_we}, 0);
    chk("rst_rsp_err", rsp_err, 0);
    rst = 1'b0; rst3 = 1'b0;
    @(negedge clk);

    // write 0xA5 to GPIO_OUT
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h02; req_wdata = 32'hA5;
    chk("wr_ready_c", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("wr_we_c1", opb_we, 4'b0001);
    chk("wr_re_c1", opb_re, 0);
    chk("wr_addr_c1", opb_addr, 32'h02);
    chk("wr_wdata_c1", opb_wdata, 32'hA5);
    chk("wr_rsp_c1", rsp_valid, 0);
    chk("wr_busy_c1", busy, 1);
    @(negedge clk);
    chk("wr_we_c2", opb_we, 0);
    chk("wr_rsp_c2", rsp_valid, 1);
    chk("wr_err_c2", rsp_err, 0);
    chk("wr_rdata_c2", rsp_rdata, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("wr_rsp_done", rsp_valid, 0);
    chk("wr_idle", req_ready, 1);

    // read back, RD_LAT=1
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h02; req_wdata = 32'h0;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rd_re_c1", opb_re, 4'b0001);
    chk("rd_we_c1", opb_we, 0);
    @(negedge clk);
    chk("rd_re_c2", opb_re, 0);
    chk("rd_rsp_c2", rsp_valid, 0);
    @(negedge clk);
    chk("rd_rsp_c3", rsp_valid, 1);
    chk("rd_rdata_c3", rsp_rdata, 32'hA5);
    chk("rd_err_c3", rsp_err, 0);

    // hold response 10 cycles, competing command must be ignored
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h13; req_wdata = 32'h5A;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_rdata", rsp_rdata, 32'hA5);
      chk("hold_ready", req_ready, 0);
      chk("hold_strobes", {opb_re, opb_we}, 0);
      chk("hold_addr", opb_addr, 32'h02);
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("hold_done", rsp_valid, 0);
    chk("hold_idle", req_ready, 1);
    chk("hold_addr_kept", opb_addr, 32'h02);

    // unmapped read idx 5
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h50;
    @(negedge clk);
    req_valid = 1'b0;
    chk("unm_rsp_c1", rsp_valid, 1);
    chk("unm_err_c1", rsp_err, 1);
    chk("unm_rdata_c1", rsp_rdata, 0);
    chk("unm_strobes_c1", {opb_re, opb_we}, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("unm_done", rsp_valid, 0);
    chk("unm_strobes_c2", {opb_re, opb_we}, 0);

    // back-to-back writes to 0x03, RSP_READY tied high
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h03; req_wdata = 32'h77;
    for (int k = 0; k < 9; k++) begin
      chk("b2b_ready", req_ready, (k % 3 == 0) ? 1 : 0);
      chk("b2b_we", opb_we, (k % 3 == 1) ? 4'b0001 : 4'b0000);
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("b2b_end_idle", req_ready, 1);
    rsp_ready = 1'b0;
    @(negedge clk);

    // RD_LAT=3 read: response at C+5
    req_valid3 = 1'b1; req_wr = 1'b0; req_addr = 32'h00;
    @(negedge clk);
    req_valid3 = 1'b0;
    chk("l3_re_c1", opb_re3, 4'b0001);
    repeat (3) @(negedge clk);
    chk("l3_rsp_c4", rsp_valid3, 0);
    @(negedge clk);
    chk("l3_rsp_c5", rsp_valid3, 1);
    chk("l3_rdata_c5", rsp_rdata3, 32'hCAFE0003);
    rsp_ready3 = 1'b1;
    @(negedge clk);
    rsp_ready3 = 1'b0;
    chk("l3_done", rsp_valid3, 0);

    // reset pulse during WAIT
    req_valid3 = 1'b1;
    @(negedge clk);
    req_valid3 = 1'b0;
    chk("rw_re_c1", opb_re3, 4'b0001);
    @(negedge clk);
    chk("rw_busy_c2", busy3, 1);
    #2 rst3 = 1'b1;
    #1;
    chk("rw_strobes_now", {opb_re3, opb_we3}, 0);
    chk("rw_rsp_now", rsp_valid3, 0);
    chk("rw_ready_now", req_ready3, 1);
    @(negedge clk);
    rst3 = 1'b0;
    @(negedge clk);
    chk("rw_ready_after", req_ready3, 1);
    chk("rw_busy_after", busy3, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rw_no_rsp", rsp_valid3, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
